// File: rtl/xy_switch_pkg.sv
// Shared definitions for the XY mesh switch: port indices, packet field
// defaults and the deterministic column-first route function.
package xy_switch_pkg;

  localparam int unsigned PORT_NUM   = 5;
  localparam int unsigned PORT_IDX_W = 3;

  localparam logic [PORT_IDX_W-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_IDX_W-1:0] PORT_WEST  = 3'd1;
  localparam logic [PORT_IDX_W-1:0] PORT_NORTH = 3'd2;
  localparam logic [PORT_IDX_W-1:0] PORT_EAST  = 3'd3;
  localparam logic [PORT_IDX_W-1:0] PORT_SOUTH = 3'd4;

  // Packet layout: {dst_col, dst_row, payload}, column field at the MSBs.
  localparam int unsigned DEF_COL_ADDR_W = 4;
  localparam int unsigned DEF_ROW_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_PCKT_W     = DEF_COL_ADDR_W + DEF_ROW_ADDR_W + DEF_DATA_W;

  // Column is resolved first, then row; equal on both means deliver locally.
  function automatic logic [PORT_IDX_W-1:0] route_xy(
    input int unsigned dst_col,
    input int unsigned dst_row,
    input int unsigned cur_col,
    input int unsigned cur_row
  );
    logic [PORT_IDX_W-1:0] port;
    if (dst_col > cur_col)      port = PORT_EAST;
    else if (dst_col < cur_col) port = PORT_WEST;
    else if (dst_row > cur_row) port = PORT_SOUTH;
    else if (dst_row < cur_row) port = PORT_NORTH;
    else                        port = PORT_LOCAL;
    return port;
  endfunction

endpackage

// File: rtl/xy_switch_fifo.sv
// Input FIFO with first-word-fall-through head; writes while full are
// dropped and flagged by a one-cycle overflow pulse.
module xy_switch_fifo #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] head_c,
  output logic              full_c,
  output logic              empty_c,
  output logic              overflow_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned CNT_W = DEPTH_W + 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  // A read never frees space for a write in the same cycle when full.
  assign push    = wr_en_i && !full_c;
  assign pop     = rd_en_i && !empty_c;
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= wr_en_i && full_c;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xy_switch.sv
// Five-port XY-routed mesh switch: per-input FIFOs, per-output round-robin
// arbitration honouring downstream full flags, registered outputs.
module xy_switch
  import xy_switch_pkg::*;
#(
  parameter int unsigned COL_CORD        = 0,
  parameter int unsigned ROW_CORD        = 0,
  parameter int unsigned PORT_N          = PORT_NUM,
  parameter int unsigned IN_FIFO_DEPTH_W = 3,
  parameter int unsigned PCKT_COL_ADDR_W = DEF_COL_ADDR_W,
  parameter int unsigned PCKT_ROW_ADDR_W = DEF_ROW_ADDR_W,
  parameter int unsigned PCKT_DATA_W     = DEF_DATA_W,
  parameter int unsigned PCKT_W          = PCKT_COL_ADDR_W + PCKT_ROW_ADDR_W + PCKT_DATA_W,
  parameter int unsigned SW_CONFIG       = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PORT_N-1:0]        wr_en_sw_i,
  input  logic [PCKT_W*PORT_N-1:0] pckt_sw_i,
  output logic [PORT_N-1:0]        in_fifo_full_o,
  output logic [PORT_N-1:0]        in_fifo_overflow_o,
  input  logic [PORT_N-1:0]        nxt_fifo_full_i,
  input  logic [PORT_N-1:0]        nxt_fifo_overflow_i,
  output logic [PORT_N-1:0]        wr_en_sw_o,
  output logic [PCKT_W*PORT_N-1:0] pckt_sw_o
);

  localparam int unsigned COL_LSB = PCKT_W - PCKT_COL_ADDR_W;
  localparam int unsigned ROW_LSB = PCKT_DATA_W;

  if (SW_CONFIG != 0 || PORT_N != PORT_NUM) begin : g_cfg_check
    $error("xy_switch: only SW_CONFIG=0 with PORT_N=5 is supported");
  end

  logic [PORT_N-1:0]     fifo_empty;
  logic [PORT_N-1:0]     fifo_pop;
  logic [PCKT_W-1:0]     head       [PORT_N];
  logic [PORT_IDX_W-1:0] head_route [PORT_N];
  logic [PORT_N-1:0]     gnt        [PORT_N];

  // Downstream overflow is informational only.
  logic unused_nxt_ovf;
  assign unused_nxt_ovf = ^nxt_fifo_overflow_i;

  for (genvar p = 0; p < PORT_N; p++) begin : g_in
    xy_switch_fifo #(
      .DATA_W  (PCKT_W),
      .DEPTH_W (IN_FIFO_DEPTH_W)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_ni),
      .wr_en_i    (wr_en_sw_i[p]),
      .wr_data_i  (pckt_sw_i[p*PCKT_W +: PCKT_W]),
      .rd_en_i    (fifo_pop[p]),
      .head_c     (head[p]),
      .full_c     (in_fifo_full_o[p]),
      .empty_c    (fifo_empty[p]),
      .overflow_o (in_fifo_overflow_o[p])
    );

    assign head_route[p] = route_xy(32'(head[p][COL_LSB +: PCKT_COL_ADDR_W]),
                                    32'(head[p][ROW_LSB +: PCKT_ROW_ADDR_W]),
                                    COL_CORD, ROW_CORD);
  end

  for (genvar o = 0; o < PORT_N; o++) begin : g_out
    logic [PORT_N-1:0]     req;
    logic [PORT_IDX_W-1:0] rr_ptr;
    logic [PORT_IDX_W-1:0] win;
    logic                  win_vld;
    logic                  wr_en_q;
    logic [PCKT_W-1:0]     pckt_q;

    // Round-robin search starting at the pointer; a full downstream blocks all grants.
    always_comb begin
      int unsigned idx;
      req     = '0;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int i = 0; i < PORT_N; i++) begin
        req[i] = !fifo_empty[i] && (head_route[i] == PORT_IDX_W'(o));
      end
      for (int unsigned k = 0; k < PORT_N; k++) begin
        idx = (32'(rr_ptr) + k) % PORT_N;
        if (!win_vld && req[PORT_IDX_W'(idx)] && !nxt_fifo_full_i[o]) begin
          win_vld = 1'b1;
          win     = PORT_IDX_W'(idx);
        end
      end
    end

    assign gnt[o] = win_vld ? (PORT_N'(1) << win) : '0;

    always_ff @(posedge clk_i) begin
      if (rst_ni) begin
        rr_ptr  <= '0;
        wr_en_q <= 1'b0;
        pckt_q  <= '0;
      end else begin
        wr_en_q <= win_vld;
        if (win_vld) begin
          rr_ptr <= (win == PORT_IDX_W'(PORT_N - 1)) ? '0 : win + 1'b1;
          pckt_q <= head[win];
        end
      end
    end

    assign wr_en_sw_o[o]                  = wr_en_q;
    assign pckt_sw_o[o*PCKT_W +: PCKT_W] = pckt_q;
  end

  // Each input requests one output, so at most one grant bit per input is set.
  always_comb begin
    fifo_pop = '0;
    for (int o = 0; o < PORT_N; o++) begin
      fifo_pop = fifo_pop | gnt[o];
    end
  end

endmodule

// File: tb/tb_xy_switch.sv
// Directed bench for xy_switch: routing table at (0,0) and (2,2), contention,
// backpressure, FIFO full/overflow, parallel forwarding and mid-run reset.
module tb_xy_switch;

  localparam int PN = 5;
  localparam int PW = 16;

  logic            clk;
  logic            rst;
  logic [PN-1:0]   wr_en;
  logic [PW*PN-1:0] pckt_in;
  logic [PN-1:0]   nxt_full;
  logic [PN-1:0]   nxt_ovf;

  logic [PN-1:0]    full0, ovf0, wr0;
  logic [PW*PN-1:0] pk0;
  logic [PN-1:0]    full2, ovf2, wr2;
  logic [PW*PN-1:0] pk2;

  int total;
  int bad;

  xy_switch #(.COL_CORD(0), .ROW_CORD(0)) dut (
    .clk_i(clk), .rst_ni(rst), .wr_en_sw_i(wr_en), .pckt_sw_i(pckt_in),
    .in_fifo_full_o(full0), .in_fifo_overflow_o(ovf0),
    .nxt_fifo_full_i(nxt_full), .nxt_fifo_overflow_i(nxt_ovf),
    .wr_en_sw_o(wr0), .pckt_sw_o(pk0)
  );

  xy_switch #(.COL_CORD(2), .ROW_CORD(2)) dut22 (
    .clk_i(clk), .rst_ni(rst), .wr_en_sw_i(wr_en), .pckt_sw_i(pckt_in),
    .in_fifo_full_o(full2), .in_fifo_overflow_o(ovf2),
    .nxt_fifo_full_i(nxt_full), .nxt_fifo_overflow_i(nxt_ovf),
    .wr_en_sw_o(wr2), .pckt_sw_o(pk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [15:0] pckt;
    int         exp00;
    int         exp22;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input int p, input logic [15:0] v);
    pckt_in[p*PW +: PW] = v;
    wr_en[p] = 1'b1;
  endtask

  task automatic clr();
    wr_en = '0;
  endtask

  function automatic logic [15:0] sl(input logic [PW*PN-1:0] v, input int p);
    return v[p*PW +: PW];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst      = 1'b1;
    wr_en    = 5'b11111;
    pckt_in  = {5{16'h0000}};
    nxt_full = '0;
    nxt_ovf  = '0;

    vecs[0] = '{0, 16'h10AA, 3, 1};
    vecs[1] = '{0, 16'h0255, 4, 1};
    vecs[2] = '{0, 16'h0033, 0, 1};
    vecs[3] = '{1, 16'h2233, 3, 0};
    vecs[4] = '{2, 16'h2133, 3, 2};
    vecs[5] = '{3, 16'h2344, 3, 4};
    vecs[6] = '{4, 16'h3044, 3, 3};
    vecs[7] = '{0, 16'hF0FF, 3, 3};
    vecs[8] = '{2, 16'h0000, 0, 1};

    // Reset held with writes on every port
    repeat (3) step();
    check("rst_wr_en", 32'(wr0), 32'h0);
    check("rst_pckt", 32'(sl(pk0, 0) | sl(pk0, 3)), 32'h0);
    check("rst_full", 32'(full0), 32'h0);
    check("rst_ovf", 32'(ovf0), 32'h0);
    rst = 1'b0;
    clr();
    step();
    step();
    check("post_rst_wr_en", 32'(wr0), 32'h0);
    check("post_rst_full", 32'(full0), 32'h0);

    // Contention for local output, pointer starts at 0
    put(0, 16'h00A0); put(1, 16'h00A1); put(2, 16'h00A2);
    step(); clr(); step();
    check("cont_wr0", 32'(wr0), 32'h1);
    check("cont_d0", 32'(sl(pk0, 0)), 32'h00A0);
    step();
    check("cont_wr1", 32'(wr0), 32'h1);
    check("cont_d1", 32'(sl(pk0, 0)), 32'h00A1);
    step();
    check("cont_wr2", 32'(wr0), 32'h1);
    check("cont_d2", 32'(sl(pk0, 0)), 32'h00A2);
    step();
    check("cont_idle", 32'(wr0), 32'h0);
    // Pointer now 3: port 3 must beat port 0
    put(0, 16'h00B0); put(3, 16'h00B3);
    step(); clr(); step();
    check("ptr3_first", 32'(sl(pk0, 0)), 32'h00B3);
    step();
    check("ptr3_second", 32'(sl(pk0, 0)), 32'h00B0);
    check("ptr3_second_wr", 32'(wr0), 32'h1);
    repeat (3) step();

    // Routing table on both switch positions
    for (int v = 0; v < 9; v++) begin
      put(vecs[v].port, vecs[v].pckt);
      step(); clr(); step();
      check($sformatf("route00_wr[%0d]", v), 32'(wr0), 32'(1) << vecs[v].exp00);
      check($sformatf("route00_d[%0d]", v), 32'(sl(pk0, vecs[v].exp00)), 32'(vecs[v].pckt));
      check($sformatf("route22_wr[%0d]", v), 32'(wr2), 32'(1) << vecs[v].exp22);
      check($sformatf("route22_d[%0d]", v), 32'(sl(pk2, vecs[v].exp22)), 32'(vecs[v].pckt));
      step();
    end

    // Parallel forwarding: local->east, west->south, exact 2-cycle latency
    put(0, 16'h1077); put(1, 16'h0188);
    step(); clr();
    check("par_lat1", 32'(wr0), 32'h0);
    step();
    check("par_wr", 32'(wr0), 32'h18);
    check("par_east", 32'(sl(pk0, 3)), 32'h1077);
    check("par_south", 32'(sl(pk0, 4)), 32'h0188);
    step();

    // Backpressure on east
    nxt_full = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      put(0, 16'(16'h10C0 + i));
      step();
      check($sformatf("bp_hold[%0d]", i), 32'(wr0[3]), 32'h0);
    end
    clr();
    repeat (2) step();
    check("bp_hold_late", 32'(wr0[3]), 32'h0);
    nxt_full = '0;
    step();
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_wr[%0d]", j), 32'(wr0[3]), 32'h1);
      check($sformatf("bp_d[%0d]", j), 32'(sl(pk0, 3)), 32'(16'h10C0 + j));
      step();
    end
    check("bp_done", 32'(wr0[3]), 32'h0);

    // FIFO full and overflow on west input
    nxt_full = 5'b01000;
    for (int i = 0; i < 9; i++) begin
      put(1, 16'(16'h1100 + i));
      step();
      if (i == 6) check("fifo_not_full7", 32'(full0[1]), 32'h0);
      if (i == 7) begin
        check("fifo_full8", 32'(full0[1]), 32'h1);
        check("fifo_no_ovf8", 32'(ovf0[1]), 32'h0);
      end
      if (i == 8) begin
        check("fifo_ovf9", 32'(ovf0[1]), 32'h1);
        check("fifo_full9", 32'(full0[1]), 32'h1);
      end
    end
    clr();
    step();
    check("fifo_ovf_pulse_end", 32'(ovf0[1]), 32'h0);
    nxt_full = '0;
    step();
    for (int j = 0; j < 8; j++) begin
      check($sformatf("fifo_wr[%0d]", j), 32'(wr0[3]), 32'h1);
      check($sformatf("fifo_d[%0d]", j), 32'(sl(pk0, 3)), 32'(16'h1100 + j));
      step();
    end
    check("fifo_only8", 32'(wr0[3]), 32'h0);
    check("fifo_drained_full", 32'(full0[1]), 32'h0);

    // Reset mid-operation discards queued packets
    nxt_full = 5'b01000;
    put(0, 16'h1055); step();
    put(0, 16'h1056); step();
    clr();
    rst = 1'b1;
    step();
    check("midrst_pckt", 32'(sl(pk0, 3) | sl(pk0, 0) | sl(pk0, 4)), 32'h0);
    check("midrst_wr", 32'(wr0), 32'h0);
    rst = 1'b0;
    nxt_full = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst_nodeliver[%0d]", i), 32'(wr0), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
